tanh_cordic: RTL

//  Hyperbolic-tangent engine, the inverse of our atanh unit: angle in, tanh out.
//  - Input a_fix: signed, LSB = pi/512 rad. Output tanha_fix: signed, LSB = 1/256.
//  - Multi-cycle datapath: CORDIC hyperbolic rotation on |a|/2, then one multiply

---
 rtl/tanh_cordic.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/tanh_cordic.sv
// tanh_cordic -- hyperbolic-tangent engine (angle in, tanh out).
//
// Computes tanh(a) by first running a hyperbolic CORDIC rotation on |a|/2,
// which yields x ~ K*cosh(a/2) and y ~ K*sinh(a/2). It then forms
// tanh(a) = 2xy / (x^2 + y^2), so the CORDIC gain K cancels out. The quotient
// comes from a restoring divider, one bit per clock.
//
// Handshake: trig is sampled only while idle. On the accepting edge a_fix is
// captured and busy rises. busy stays high until the result edge. On that edge
// vld pulses for exactly one clock and tanha_fix is updated. tanha_fix then
// holds its value until the next result. A trig that arrives while busy is
// dropped, not queued.
//
// Ports:
//   clk          in   1    clock, rising edge
//   rstn         in   1    asynchronous reset, active-high
//   trig         in   1    start pulse
//   a_fix        in   AW   signed angle, LSB = pi/512 rad
//   busy         out  1    operation in progress
//   vld          out  1    one-cycle result strobe
//   tanha_fix    out  OW   signed tanh(a), OW-1 fractional bits
//   dbg_state_o  out  3    current FSM state
//
// The ATANH table and the pi/1024 scale are tabulated at 16 fractional bits.
// They are shifted up when DW > 18, so DW must be at least 18.
module tanh_cordic #(
   parameter int AW     = 9,
   parameter int OW     = 9,
   parameter int DW     = 18,
   parameter int N_ITER = 12
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          trig,
   input  logic [AW-1:0] a_fix,
   output logic          busy,
   output logic          vld,
   output logic [OW-1:0] tanha_fix,
   output logic [2:0]    dbg_state_o
);

   localparam int N_ROT = N_ITER + ((N_ITER >= 13) ? 2 : 1);
   localparam int CNTW  = $clog2(((N_ROT > OW) ? N_ROT : OW) + 1);
   localparam int PW    = 2 * DW;

   localparam logic signed [DW-1:0] X_ONE   = {2'b01, {(DW-2){1'b0}}};
   // round(pi/1024 * 2^16) = 201: converts one input LSB into radians of a/2.
   localparam logic [DW-1:0]        Z_SCALE = DW'(32'd201 << (DW-18));
   localparam logic [OW-1:0]        OUT_MAX = OW'((1 << (OW-1)) - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ROT  = 3'd1,
      S_MUL  = 3'd2,
      S_DIV  = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   // Shift index for rotation step k. The sequence is 1,2,3,4,4,5,...,13,13,...
   // The repeats at 4 and 13 make the hyperbolic CORDIC converge.
   function automatic logic [4:0] iter_idx(input logic [CNTW-1:0] k);
      int kk;
      kk = int'(k);
      if (kk <= 3)       kk = kk + 1;
      else if (kk >= 14) kk = kk - 1;
      return 5'(kk);
   endfunction

   // atanh(2^-i) at 16 fractional bits. From i = 7 on, this is 2^(16-i)
   // after rounding.
   function automatic logic signed [DW-1:0] atanh_lut(input logic [4:0] i);
      logic [31:0] base;
      case (i)
         5'd1:    base = 32'd35999;
         5'd2:    base = 32'd16739;
         5'd3:    base = 32'd8235;
         5'd4:    base = 32'd4101;
         5'd5:    base = 32'd2049;
         5'd6:    base = 32'd1024;
         default: base = 32'd65536 >> i;
      endcase
      return DW'(base << (DW-18));
   endfunction

   state_t                 state_q;
   logic                   busy_q, vld_q, sgn_q;
   logic [OW-1:0]          out_q;
   logic [CNTW-1:0]        cnt_q;
   logic signed [DW-1:0]   x_q, y_q, z_q;
   logic [PW-1:0]          den_q, rem_q;
   logic [OW-2:0]          quo_q;

   logic [AW:0]            ext_d, mag_d;
   logic signed [DW-1:0]   z_init_d, lut_d, xs_d, ys_d;
   logic signed [DW-1:0]   x_rot_d, y_rot_d, z_rot_d;
   logic [4:0]             shift_d;
   logic signed [PW-1:0]   xx_d, yy_d, xy_d;
   logic [PW-1:0]          num_d, den_d, rem_div_d;
   logic [PW:0]            rem_sh_d;
   logic                   qbit_d;
   logic [OW-1:0]          r_d, r_sat_d, out_d;

   always_comb begin
      // |a_fix| needs AW+1 bits so that the most negative input stays positive.
      ext_d    = {a_fix[AW-1], a_fix};
      mag_d    = ext_d[AW] ? (~ext_d + (AW+1)'(1)) : ext_d;
      z_init_d = $signed(DW'(mag_d) * Z_SCALE);

      shift_d  = iter_idx(cnt_q);
      lut_d    = atanh_lut(shift_d);
      xs_d     = x_q >>> shift_d;
      ys_d     = y_q >>> shift_d;
      // z == 0 counts as a positive direction.
      if (!z_q[DW-1]) begin
         x_rot_d = x_q + ys_d;
         y_rot_d = y_q + xs_d;
         z_rot_d = z_q - lut_d;
      end else begin
         x_rot_d = x_q - ys_d;
         y_rot_d = y_q - xs_d;
         z_rot_d = z_q + lut_d;
      end

      xx_d  = PW'(x_q) * PW'(x_q);
      yy_d  = PW'(y_q) * PW'(y_q);
      xy_d  = PW'(x_q) * PW'(y_q);
      den_d = $unsigned(xx_d + yy_d);
      // For a = 0 the residual angle can leave y a few LSBs below zero.
      // The true answer is 0 there, so clamp.
      num_d = y_q[DW-1] ? '0 : $unsigned(xy_d <<< 1);

      rem_sh_d  = {rem_q, 1'b0};
      qbit_d    = (rem_sh_d >= {1'b0, den_q});
      rem_div_d = qbit_d ? PW'(rem_sh_d - {1'b0, den_q}) : PW'(rem_sh_d);

      // In OUT, qbit_d is exactly the round-half-up test 2*rem >= den.
      r_d     = OW'(quo_q) + OW'(qbit_d);
      r_sat_d = (r_d > OUT_MAX) ? OUT_MAX : r_d;
      out_d   = sgn_q ? (~r_sat_d + OW'(1)) : r_sat_d;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
         sgn_q   <= 1'b0;
         out_q   <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
      end else begin
         vld_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trig) begin
                  sgn_q   <= a_fix[AW-1];
                  z_q     <= z_init_d;
                  x_q     <= X_ONE;
                  y_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ROT;
               end
            end
            S_ROT: begin
               x_q <= x_rot_d;
               y_q <= y_rot_d;
               z_q <= z_rot_d;
               if (cnt_q == CNTW'(N_ROT - 1)) begin
                  cnt_q   <= '0;
                  state_q <= S_MUL;
               end else begin
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            S_MUL: begin
               den_q   <= den_d;
               rem_q   <= num_d;
               quo_q   <= '0;
               cnt_q   <= '0;
               state_q <= S_DIV;
            end
            S_DIV: begin
               rem_q <= rem_div_d;
               quo_q <= {quo_q[OW-3:0], qbit_d};
               if (cnt_q == CNTW'(OW - 2)) begin
                  cnt_q   <= '0;
                  state_q <= S_OUT;
               end else begin
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            S_OUT: begin
               out_q   <= out_d;
               vld_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign vld         = vld_q;
   assign tanha_fix   = out_q;
   assign dbg_state_o = state_q;

endmodule
